sdm_codec: RTL and testbench

SDM_CODEC -- requirements
Module: sdm_codec

---
 rtl/sdm_codec.sv | 207 ++++++++++++++++++++
 tb/tb_sdm_codec.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_codec.sv
// -----------------------------------------------------------------------------
// sdm_codec
//   1-bit sigma-delta audio codec with two independent paths:
//     DAC: 16-bit PCM -> 1st or 2nd order sigma-delta modulator -> 1-bit stream
//     ADC: 1-bit stream -> boxcar (count-the-ones) decimator by N = 2^ADC_LOG2_DECIM
//
// Parameters
//   DAC_ORDER       modulator order, 1 or 2 (anything else stops elaboration)
//   ADC_LOG2_DECIM  log2 of the ADC decimation ratio, 1..15
//
// Optional feature
//   SDM_DITHER_EN   when defined, a 16-bit Fibonacci LFSR adds a small signed
//                   dither to the DAC quantizer input (not to integrator state).
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   valid_in_dac   audio_in holds a valid PCM sample
//   audio_in       signed 16-bit PCM sample into the DAC
//   valid_in_adc   sdm_in holds a valid bitstream bit
//   sdm_in         ADC bitstream (1 = +full scale, 0 = -full scale)
//   valid_out_dac  sdm_out was updated this cycle
//   sdm_out        DAC bitstream, registered
//   valid_out_adc  one-cycle pulse when audio_out carries a new sample
//   audio_out      signed 16-bit decimated PCM, registered
// -----------------------------------------------------------------------------
module sdm_codec #(
    parameter int DAC_ORDER      = 2,
    parameter int ADC_LOG2_DECIM = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in_dac,
    input  logic signed [15:0] audio_in,
    input  logic               valid_in_adc,
    input  logic               sdm_in,
    output logic               valid_out_dac,
    output logic               sdm_out,
    output logic               valid_out_adc,
    output logic signed [15:0] audio_out
);

    localparam int ADC_N  = 1 << ADC_LOG2_DECIM;
    localparam int CNT_W  = ADC_LOG2_DECIM + 1;

    generate
        if (DAC_ORDER != 1 && DAC_ORDER != 2) begin : g_bad_order
            $error("sdm_codec: DAC_ORDER must be 1 or 2");
        end
        if (ADC_LOG2_DECIM < 1 || ADC_LOG2_DECIM > 15) begin : g_bad_decim
            $error("sdm_codec: ADC_LOG2_DECIM must be in 1..15");
        end
    endgenerate

    // =========================================================================
    // DAC path
    // =========================================================================
    logic signed [15:0] fb_val;
    logic signed [4:0]  dither_val;
    logic               quant_bit;

    // Feedback follows the previous output bit; after reset sdm_out = 0 so the
    // modulator starts from fb = -32768.
    assign fb_val = sdm_out ? 16'sh7FFF : 16'sh8000;

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    // Taps 16,14,13,11 (1-based) map to bits 15,13,12,10.
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= 16'hACE1;
        end else if (valid_in_dac) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

    assign dither_val = {lfsr_reg[3], lfsr_reg[3:0]};
`else
    assign dither_val = '0;
`endif

    function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
        if (v > 26'sd8388607) begin
            sat24 = 24'sd8388607;
        end else if (v < -26'sd8388607) begin
            sat24 = -24'sd8388607;
        end else begin
            sat24 = v[23:0];
        end
    endfunction

    generate
        if (DAC_ORDER == 1) begin : g_order1
            // 18 bits hold |i1| <= 2*65535 without saturation.
            logic signed [17:0] i1_reg;
            logic signed [17:0] i1_next;
            logic signed [18:0] q_val;

            assign i1_next   = i1_reg + 18'(audio_in) - 18'(fb_val);
            // Dither only biases the comparison, never the stored state.
            assign q_val     = 19'(i1_next) + 19'(dither_val);
            assign quant_bit = ~q_val[18];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    i1_reg <= '0;
                end else if (valid_in_dac) begin
                    i1_reg <= i1_next;
                end
            end
        end else begin : g_order2
            logic signed [23:0] i1_reg;
            logic signed [23:0] i2_reg;
            logic signed [23:0] i1_next;
            logic signed [23:0] i2_next;
            logic signed [25:0] sum1;
            logic signed [25:0] sum2;
            logic signed [24:0] q_val;

            // Sums are formed two bits wider than the state so the clamp sees
            // the true value before it is folded back into 24 bits.
            assign sum1      = 26'(i1_reg) + 26'(audio_in) - 26'(fb_val);
            assign i1_next   = sat24(sum1);
            assign sum2      = 26'(i2_reg) + 26'(i1_next) - 26'(fb_val);
            assign i2_next   = sat24(sum2);
            assign q_val     = 25'(i2_next) + 25'(dither_val);
            assign quant_bit = ~q_val[24];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    i1_reg <= '0;
                    i2_reg <= '0;
                end else if (valid_in_dac) begin
                    i1_reg <= i1_next;
                    i2_reg <= i2_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdm_out       <= 1'b0;
            valid_out_dac <= 1'b0;
        end else begin
            valid_out_dac <= valid_in_dac;
            if (valid_in_dac) begin
                sdm_out <= quant_bit;
            end
        end
    end

    // =========================================================================
    // ADC path
    // =========================================================================
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [CNT_W-1:0]   ones_reg;
    logic [CNT_W-1:0]   ones_total;
    logic               window_done;
    logic signed [17:0] diff_val;
    logic signed [17:0] scaled_val;
    logic signed [15:0] pcm_next;

    // The bit arriving now is part of the window it closes.
    assign ones_total  = ones_reg + CNT_W'(sdm_in);
    assign window_done = valid_in_adc && (bit_cnt_reg == CNT_W'(ADC_N - 1));

    // 2*ones - N spans -N..+N; scaling to 16-bit full scale only overflows at
    // the all-ones window (+32768), which the clamp folds to +32767.
    assign diff_val   = 18'(ones_total) * 18'd2 - 18'(ADC_N);
    assign scaled_val = diff_val <<< (15 - ADC_LOG2_DECIM);

    always_comb begin
        pcm_next = scaled_val[15:0];
        if (scaled_val > 18'sd32767) begin
            pcm_next = 16'sh7FFF;
        end else if (scaled_val < -18'sd32768) begin
            pcm_next = 16'sh8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg   <= '0;
            ones_reg      <= '0;
            valid_out_adc <= 1'b0;
            audio_out     <= '0;
        end else begin
            valid_out_adc <= window_done;
            if (valid_in_adc) begin
                if (window_done) begin
                    bit_cnt_reg <= '0;
                    ones_reg    <= '0;
                    audio_out   <= pcm_next;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    ones_reg    <= ones_total;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdm_codec.sv
// -----------------------------------------------------------------------------
// tb_sdm_codec
//   Two codec instances share clock, reset and DAC stimulus: u_dut1 runs a
//   first-order DAC, u_dut2 a second-order DAC, both with N = 64 decimation.
//   ADC windows come from a vector table; DAC behaviour is checked against an
//   integer reference model plus ones-density targets; a loopback run feeds
//   u_dut2's bitstream back into its own ADC.
// -----------------------------------------------------------------------------
module tb_sdm_codec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n = 1'b1;
    logic               valid_in_dac = 1'b0;
    logic signed [15:0] audio_in = '0;
    logic               adc_v = 1'b0;
    logic               adc_b = 1'b0;
    logic               loop_en = 1'b0;

    logic               vod1, so1, voa1;
    logic signed [15:0] ao1;
    logic               vod2, so2, voa2;
    logic signed [15:0] ao2;
    logic               vin_adc2, sin_adc2;

    assign vin_adc2 = loop_en ? vod2 : adc_v;
    assign sin_adc2 = loop_en ? so2  : adc_b;

    sdm_codec #(.DAC_ORDER(1), .ADC_LOG2_DECIM(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .valid_in_dac(valid_in_dac), .audio_in(audio_in),
        .valid_in_adc(adc_v), .sdm_in(adc_b),
        .valid_out_dac(vod1), .sdm_out(so1),
        .valid_out_adc(voa1), .audio_out(ao1)
    );

    sdm_codec #(.DAC_ORDER(2), .ADC_LOG2_DECIM(6)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .valid_in_dac(valid_in_dac), .audio_in(audio_in),
        .valid_in_adc(vin_adc2), .sdm_in(sin_adc2),
        .valid_out_dac(vod2), .sdm_out(so2),
        .valid_out_adc(voa2), .audio_out(ao2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=[%0d..%0d]", name, act, lo, hi);
        end else begin
            $display("ok   %s = %0d in [%0d..%0d]", name, act, lo, hi);
        end
    endtask

    // ---------------- DAC reference model (integer arithmetic) --------------
    function automatic int fbv(input int q);
        return (q != 0) ? 32767 : -32768;
    endfunction

    function automatic int sat23(input int v);
        if (v > 8388607)  return 8388607;
        if (v < -8388607) return -8388607;
        return v;
    endfunction

    int   m1_i, m1_q, m2_i1, m2_i2, m2_q;
    logic vin_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_i  <= 0; m1_q  <= 0;
            m2_i1 <= 0; m2_i2 <= 0; m2_q <= 0;
            vin_d <= 1'b0;
        end else begin : upd
            int a, t, u1, u2;
            vin_d <= valid_in_dac;
            if (valid_in_dac) begin
                a  = int'(audio_in);
                t  = m1_i + a - fbv(m1_q);
                u1 = sat23(m2_i1 + a - fbv(m2_q));
                u2 = sat23(m2_i2 + u1 - fbv(m2_q));
                m1_i  <= t;
                m1_q  <= (t >= 0) ? 1 : 0;
                m2_i1 <= u1;
                m2_i2 <= u2;
                m2_q  <= (u2 >= 0) ? 1 : 0;
            end
        end
    end

    // ---------------- Monitor: running tallies, sampled on negedge ----------
    int mism1 = 0, mism2 = 0, lat_err = 0;
    int outs1 = 0, ones1 = 0, outs2 = 0, ones2 = 0;
    int pc1 = 0, pc2 = 0, last1 = 0, last2 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (so1 != (m1_q != 0)) mism1 <= mism1 + 1;
            if (so2 != (m2_q != 0)) mism2 <= mism2 + 1;
            if (vod1 != vin_d || vod2 != vin_d) lat_err <= lat_err + 1;
            if (vod1) begin
                outs1 <= outs1 + 1;
                if (so1) ones1 <= ones1 + 1;
            end
            if (vod2) begin
                outs2 <= outs2 + 1;
                if (so2) ones2 <= ones2 + 1;
            end
            if (voa1) begin
                pc1   <= pc1 + 1;
                last1 <= int'(ao1);
            end
            if (voa2) begin
                pc2   <= pc2 + 1;
                last2 <= int'(ao2);
            end
        end
    end

    // ---------------- Helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset off-edge, optionally checks every output is already 0,
    // then releases at a negedge so the next posedge accepts input.
    task automatic do_reset(input bit chk);
        valid_in_dac = 1'b0;
        adc_v        = 1'b0;
        adc_b        = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        if (chk) begin
            check("rst_sdm_out1",   int'(so1),  0);
            check("rst_vout_dac1",  int'(vod1), 0);
            check("rst_vout_adc1",  int'(voa1), 0);
            check("rst_audio_out1", int'(ao1),  0);
            check("rst_sdm_out2",   int'(so2),  0);
            check("rst_vout_dac2",  int'(vod2), 0);
            check("rst_vout_adc2",  int'(voa2), 0);
            check("rst_audio_out2", int'(ao2),  0);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic dac_run(input int sample, input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            valid_in_dac = 1'b1;
            audio_in     = 16'(sample);
            tick();
            if (gapped) begin
                valid_in_dac = 1'b0;
                tick();
            end
        end
        valid_in_dac = 1'b0;
        tick();
        tick();
    endtask

    task automatic adc_window(input int k_ones, input bit alt, input bit gapped);
        for (int i = 0; i < 64; i++) begin
            adc_v = 1'b1;
            adc_b = alt ? (i % 2 == 0) : (i < k_ones);
            tick();
            if (gapped) begin
                adc_v = 1'b0;
                tick();
            end
        end
        adc_v = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        int k_ones;
        bit alt;
        bit gapped;
        int exp;
    } adc_vec_t;

    adc_vec_t vecs[8];

    initial begin
        int s1, s2, so, sm1, sm2, sl, sp;

        // {ones at start of window, alternating, 50% gapped, expected PCM}
        vecs[0] = '{64, 1'b0, 1'b0,  32767};
        vecs[1] = '{ 0, 1'b0, 1'b0, -32768};
        vecs[2] = '{ 0, 1'b1, 1'b0,      0};
        vecs[3] = '{48, 1'b0, 1'b0,  16384};
        vecs[4] = '{63, 1'b0, 1'b0,  31744};
        vecs[5] = '{ 1, 1'b0, 1'b0, -31744};
        vecs[6] = '{ 0, 1'b1, 1'b1,      0};
        vecs[7] = '{64, 1'b0, 1'b1,  32767};

        do_reset(1'b1);

        // ---------------- ADC vector table ----------------
        for (int v = 0; v < 8; v++) begin
            s1 = pc1;
            s2 = pc2;
            adc_window(vecs[v].k_ones, vecs[v].alt, vecs[v].gapped);
            check($sformatf("adc_v%0d_pulses1", v), pc1 - s1, 1);
            check($sformatf("adc_v%0d_pulses2", v), pc2 - s2, 1);
            check($sformatf("adc_v%0d_pcm1", v), last1, vecs[v].exp);
            check($sformatf("adc_v%0d_pcm2", v), last2, vecs[v].exp);
        end

        // Async reset while outputs hold a nonzero sample.
        do_reset(1'b1);

        // ---------------- Back-to-back windows: boundary ----------------
        s1 = pc1;
        for (int i = 0; i < 128; i++) begin
            adc_v = 1'b1;
            adc_b = (i < 64);
            tick();
            if (i == 64) begin
                check("bound_first_pulses", pc1 - s1, 1);
                check("bound_first_pcm", last1, 32767);
            end
        end
        adc_v = 1'b0;
        tick();
        tick();
        check("bound_total_pulses", pc1 - s1, 2);
        check("bound_second_pcm", last1, -32768);

        // ---------------- Reset mid-window discards partial ----------------
        s1 = pc1;
        for (int i = 0; i < 30; i++) begin
            adc_v = 1'b1;
            adc_b = 1'b1;
            tick();
        end
        do_reset(1'b0);
        check("midrst_no_pulse", pc1 - s1, 0);
        check("midrst_pcm_cleared", int'(ao1), 0);
        s1 = pc1;
        adc_window(16, 1'b0, 1'b0);
        check("midrst_next_pulses", pc1 - s1, 1);
        check("midrst_next_pcm", last1, -16384);

        // ---------------- DAC: +full scale, order 1 ----------------
        do_reset(1'b0);
        so = outs1; s1 = ones1; sm1 = mism1; sl = lat_err;
        dac_run(32767, 100, 1'b0);
        check("dac_pfs_outs1", outs1 - so, 100);
        check("dac_pfs_ones1", ones1 - s1, 100);
        check("dac_pfs_model1", mism1 - sm1, 0);
        check("dac_pfs_latency", lat_err - sl, 0);

        // ---------------- DAC: -full scale, order 1 ----------------
        do_reset(1'b0);
        so = outs1; s1 = ones1; sm1 = mism1;
        dac_run(-32768, 50, 1'b0);
        check("dac_nfs_outs1", outs1 - so, 50);
        check("dac_nfs_ones1", ones1 - s1, 1);
        check("dac_nfs_final1", int'(so1), 0);
        check("dac_nfs_model1", mism1 - sm1, 0);

        // ---------------- DAC density: 0 and half-scale ----------------
        do_reset(1'b0);
        s1 = ones1; s2 = ones2; sm1 = mism1; sm2 = mism2;
        dac_run(0, 4096, 1'b0);
        check_rng("dac_zero_ones1", ones1 - s1, 2044, 2052);
        check_rng("dac_zero_ones2", ones2 - s2, 2044, 2052);
        check("dac_zero_model1", mism1 - sm1, 0);
        check("dac_zero_model2", mism2 - sm2, 0);

        do_reset(1'b0);
        s1 = ones1; s2 = ones2; sm1 = mism1; sm2 = mism2; sl = lat_err;
        dac_run(16384, 4096, 1'b0);
        check_rng("dac_half_ones1", ones1 - s1, 3064, 3080);
        check_rng("dac_half_ones2", ones2 - s2, 3064, 3080);
        check("dac_half_model1", mism1 - sm1, 0);
        check("dac_half_model2", mism2 - sm2, 0);
        check("dac_half_latency", lat_err - sl, 0);

        // ---------------- DAC gapped: state holds between samples ----------
        do_reset(1'b0);
        so = outs2; sm1 = mism1; sm2 = mism2; sl = lat_err;
        dac_run(-12000, 500, 1'b1);
        check("dac_gap_outs2", outs2 - so, 500);
        check("dac_gap_model1", mism1 - sm1, 0);
        check("dac_gap_model2", mism2 - sm2, 0);
        check("dac_gap_latency", lat_err - sl, 0);

        // ---------------- Loopback: order-2 DAC into ADC ----------------
        do_reset(1'b0);
        loop_en      = 1'b1;
        valid_in_dac = 1'b1;
        audio_in     = -16'sd8192;
        sp = pc2;
        for (int i = 0; i < 64 * 8; i++) tick();
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 64; i++) tick();
            check_rng($sformatf("loop_pcm_w%0d", w), last2, -9216, -7168);
        end
        check_rng("loop_pulses", pc2 - sp, 10, 12);
        valid_in_dac = 1'b0;
        loop_en      = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard ceiling so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
